// File: rtl/exec_unit_seq_if.sv
// Issue-side and writeback-side handshake bundle for exec_unit_seq.
// The unit itself uses the slave modport; the issuing/consuming side uses master.
interface exec_unit_seq_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [XLEN-1:0]  imm_val;
    logic             op1_sel;
    logic             op2_sel;
    logic [3:0]       exec_op;
    logic             md_sel;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  exec_out;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output in_valid, pc, rs1, rs2, imm_val, op1_sel, op2_sel, exec_op, md_sel, in_tag,
               flush, out_ready,
        input  in_ready, out_valid, exec_out, out_tag, busy
    );

    modport slave (
        input  in_valid, pc, rs1, rs2, imm_val, op1_sel, op2_sel, exec_op, md_sel, in_tag,
               flush, out_ready,
        output in_ready, out_valid, exec_out, out_tag, busy
    );
endinterface

// File: rtl/exec_unit_seq.sv
// Integer execute unit: RV ALU ops with a registered valid/ready output and flush.
// Define EXEC_UNIT_MULDIV_EN to build the iterative multiply/divide FSM (MUL/DIV states, busy).
module exec_unit_seq #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    exec_unit_seq_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0]  op1, op2, alu_res;
    logic [SHW-1:0]   shamt;
    logic             idle, accept;
    logic             one_cycle, md_done;
    logic [XLEN-1:0]  one_cycle_res, md_res;
    logic [TAG_W-1:0] md_tag;

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  exec_out_q, exec_out_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    assign op1   = bus.op1_sel ? bus.pc : bus.rs1;
    assign op2   = bus.op2_sel ? bus.imm_val : bus.rs2;
    assign shamt = op2[SHW-1:0];

    // A held result blocks issue unless it is being consumed this cycle.
    assign bus.in_ready = idle && !bus.flush && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        alu_res = '0;
        unique case (bus.exec_op[2:0])
            3'b000: alu_res = bus.exec_op[3] ? (op1 - op2) : (op1 + op2);
            3'b001: alu_res = op1 << shamt;
            3'b010: alu_res = XLEN'($signed(op1) < $signed(op2));
            3'b011: alu_res = XLEN'(op1 < op2);
            3'b100: alu_res = op1 ^ op2;
            3'b101: alu_res = bus.exec_op[3] ? $unsigned($signed(op1) >>> shamt) : (op1 >> shamt);
            3'b110: alu_res = op1 | op2;
            3'b111: alu_res = op1 & op2;
            default: alu_res = '0;
        endcase
    end

`ifdef EXEC_UNIT_MULDIV_EN
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

    state_t            state_q, state_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic              neg_q, neg_d;
    logic              upper_q, upper_d;
    logic [TAG_W-1:0]  tag_q, tag_d;

    logic [2:0]        f3;
    logic              is_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf, special, last;
    logic [XLEN-1:0]   a_mag, b_mag, special_res, div_val;
    logic [XLEN:0]     mul_sum, div_rem, div_diff;
    logic [2*XLEN-1:0] mul_acc, div_acc, mul_prod;

    assign f3       = bus.exec_op[2:0];
    assign is_div   = f3[2];
    assign a_sgn    = is_div ? !f3[0] : (f3[1] ^ f3[0]);
    assign b_sgn    = is_div ? !f3[0] : (f3[1:0] == 2'b01);
    assign a_neg    = a_sgn && op1[XLEN-1];
    assign b_neg    = b_sgn && op2[XLEN-1];
    assign a_mag    = a_neg ? -op1 : op1;
    assign b_mag    = b_neg ? -op2 : op2;
    assign div_zero = is_div && (op2 == '0);
    assign div_ovf  = is_div && !f3[0] && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
    assign special  = div_zero || div_ovf;
    // Overflow: quotient is the dividend itself (most-negative), remainder 0.
    assign special_res = div_zero ? (f3[1] ? op1 : '1) : (f3[1] ? '0 : op1);

    // acc holds {high partial product, multiplier} or {remainder, dividend/quotient}.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    assign mul_acc  = {mul_sum, acc_q[XLEN-1:1]};
    assign mul_prod = neg_q ? -mul_acc : mul_acc;
    assign div_rem  = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff = div_rem - {1'b0, dvs_q};
    assign div_acc  = div_diff[XLEN] ? {div_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    assign div_val  = upper_q ? div_acc[2*XLEN-1:XLEN] : div_acc[XLEN-1:0];
    assign last     = (cnt_q == SHW'(XLEN-1));

    assign idle          = (state_q == ST_IDLE);
    assign bus.busy      = !idle;
    assign one_cycle     = !bus.md_sel || special;
    assign one_cycle_res = bus.md_sel ? special_res : alu_res;
    assign md_done       = !idle && last;
    assign md_res        = (state_q == ST_MUL)
                         ? (upper_q ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0])
                         : (neg_q ? -div_val : div_val);
    assign md_tag        = tag_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        neg_d   = neg_q;
        upper_d = upper_q;
        tag_d   = tag_q;
        if (bus.flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept && !one_cycle) begin
                        state_d = is_div ? ST_DIV : ST_MUL;
                        cnt_d   = '0;
                        acc_d   = {{XLEN{1'b0}}, a_mag};
                        dvs_d   = b_mag;
                        // Remainder follows the dividend's sign; everything else the product of signs.
                        neg_d   = (is_div && f3[1]) ? a_neg : (a_neg ^ b_neg);
                        upper_d = is_div ? f3[1] : (f3[1:0] != 2'b00);
                        tag_d   = bus.in_tag;
                    end
                end
                ST_MUL, ST_DIV: begin
                    acc_d = (state_q == ST_MUL) ? mul_acc : div_acc;
                    cnt_d = cnt_q + SHW'(1);
                    if (last) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            neg_q   <= 1'b0;
            upper_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            neg_q   <= neg_d;
            upper_q <= upper_d;
            tag_q   <= tag_d;
        end
    end
`else
    assign idle          = 1'b1;
    assign bus.busy      = 1'b0;
    assign one_cycle     = 1'b1;
    assign one_cycle_res = bus.md_sel ? '0 : alu_res;
    assign md_done       = 1'b0;
    assign md_res        = '0;
    assign md_tag        = '0;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        exec_out_d  = exec_out_q;
        out_tag_d   = out_tag_q;
        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept && one_cycle) begin
            out_valid_d = 1'b1;
            exec_out_d  = one_cycle_res;
            out_tag_d   = bus.in_tag;
        end else if (md_done) begin
            out_valid_d = 1'b1;
            exec_out_d  = md_res;
            out_tag_d   = md_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            exec_out_q  <= '0;
            out_tag_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            exec_out_q  <= exec_out_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.exec_out  = exec_out_q;
    assign bus.out_tag   = out_tag_q;
endmodule

// File: tb/tb_exec_unit_seq.sv
// Directed self-checking bench for exec_unit_seq; expectations follow EXEC_UNIT_MULDIV_EN.
module tb_exec_unit_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    exec_unit_seq_if #(.XLEN(32), .TAG_W(5)) bus ();
    exec_unit_seq #(.XLEN(32), .TAG_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic        s1;
        logic        s2;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } alu_vec_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        special;
    } md_vec_t;

    alu_vec_t av [12];
    md_vec_t  mv [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input alu_vec_t v, input logic [4:0] tag);
        bus.in_valid = 1'b1;
        bus.md_sel   = 1'b0;
        bus.exec_op  = v.op;
        bus.op1_sel  = v.s1;
        bus.op2_sel  = v.s2;
        bus.pc       = v.s1 ? v.a : 32'hDEAD_0000;
        bus.rs1      = v.s1 ? 32'h1111_1111 : v.a;
        bus.imm_val  = v.s2 ? v.b : 32'h3333_3333;
        bus.rs2      = v.s2 ? 32'h2222_2222 : v.b;
        bus.in_tag   = tag;
    endtask

    task automatic drive_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] tag);
        bus.in_valid = 1'b1;
        bus.md_sel   = 1'b1;
        bus.exec_op  = {1'b0, f3};
        bus.op1_sel  = 1'b0;
        bus.op2_sel  = 1'b0;
        bus.rs1      = a;
        bus.rs2      = b;
        bus.pc       = 32'hDEAD_0000;
        bus.imm_val  = 32'h3333_3333;
        bus.in_tag   = tag;
    endtask

    // Issues one M op and waits (bounded) for its result; lat=0 means it never arrived.
    task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, output int lat, output int bcnt,
                          output logic [31:0] res, output logic [4:0] rtag);
        bus.out_ready = 1'b1;
        drive_md(f3, a, b, tag);
        lat  = 0;
        bcnt = 0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            bus.in_valid = 1'b0;
            if (bus.busy) bcnt++;
            if (bus.out_valid) begin
                lat = n;
                break;
            end
        end
        res  = bus.exec_out;
        rtag = bus.out_tag;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.md_sel = 1'b0; bus.exec_op = 4'h0; bus.op1_sel = 1'b0;
        bus.op2_sel = 1'b0; bus.pc = '0; bus.rs1 = '0; bus.rs2 = '0; bus.imm_val = '0;
        bus.in_tag = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.exec_out !== 32'h0) begin failures++; $display("FAIL reset_exec_out got=%h exp=0", bus.exec_out); end
        checks++; if (bus.out_tag !== 5'h0) begin failures++; $display("FAIL reset_out_tag got=%h exp=0", bus.out_tag); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_alu();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_alu(av[i], 5'(i + 1));
            checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL alu%0d_in_ready got=%b exp=1", i, bus.in_ready); end
            tick();
            bus.in_valid = 1'b0;
            checks++; if ({bus.out_valid, bus.out_tag, bus.exec_out} !== {1'b1, 5'(i + 1), av[i].exp}) begin
                failures++; $display("FAIL alu%0d_result got v=%b t=%h d=%h exp v=1 t=%h d=%h", i, bus.out_valid, bus.out_tag, bus.exec_out, 5'(i + 1), av[i].exp);
            end
            tick();
            checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL alu%0d_consumed got=%b exp=0", i, bus.out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive_alu(av[i], 5'(i + 8));
            checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b%0d_in_ready got=%b exp=1", i, bus.in_ready); end
            tick();
            checks++; if ({bus.out_valid, bus.out_tag, bus.exec_out} !== {1'b1, 5'(i + 8), av[i].exp}) begin
                failures++; $display("FAIL b2b%0d_result got v=%b t=%h d=%h exp v=1 t=%h d=%h", i, bus.out_valid, bus.out_tag, bus.exec_out, 5'(i + 8), av[i].exp);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive_alu(av[4], 5'd1);
        tick();
        drive_alu(av[7], 5'd2);
        checks++; if ({bus.out_valid, bus.in_ready} !== 2'b10) begin failures++; $display("FAIL bp_stall got v=%b rdy=%b exp v=1 rdy=0", bus.out_valid, bus.in_ready); end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if ({bus.out_valid, bus.out_tag, bus.exec_out} !== {1'b1, 5'd1, av[4].exp}) begin
                failures++; $display("FAIL bp_hold%0d got v=%b t=%h d=%h exp v=1 t=01 d=%h", k, bus.out_valid, bus.out_tag, bus.exec_out, av[4].exp);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        checks++; if ({bus.out_valid, bus.out_tag, bus.exec_out} !== {1'b1, 5'd2, av[7].exp}) begin
            failures++; $display("FAIL bp_second got v=%b t=%h d=%h exp v=1 t=02 d=%h", bus.out_valid, bus.out_tag, bus.exec_out, av[7].exp);
        end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_muldiv();
        int          lat, bcnt, elat, ebusy;
        logic [31:0] res, eres;
        logic [4:0]  rtag;
        for (int i = 0; i < 14; i++) begin
            run_md(mv[i].f3, mv[i].a, mv[i].b, 5'(i + 3), lat, bcnt, res, rtag);
`ifdef EXEC_UNIT_MULDIV_EN
            eres  = mv[i].exp;
            elat  = mv[i].special ? 1 : 33;
            ebusy = mv[i].special ? 0 : 32;
`else
            eres  = 32'h0;
            elat  = 1;
            ebusy = 0;
`endif
            checks++; if ({rtag, res} !== {5'(i + 3), eres}) begin failures++; $display("FAIL md%0d_result got t=%h d=%h exp t=%h d=%h", i, rtag, res, 5'(i + 3), eres); end
            checks++; if (lat != elat) begin failures++; $display("FAIL md%0d_latency got=%0d exp=%0d", i, lat, elat); end
            checks++; if (bcnt != ebusy) begin failures++; $display("FAIL md%0d_busy_cycles got=%0d exp=%0d", i, bcnt, ebusy); end
        end
    endtask

    task automatic test_flush();
        int seen;
        bus.out_ready = 1'b0;
        drive_alu(av[4], 5'd4);
        tick();
        drive_alu(av[7], 5'd5);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL flush_pending got=%b exp=1", bus.out_valid); end
        bus.flush = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", bus.in_ready); end
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_discard got=%b exp=0", bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_accept got=%b exp=0", bus.out_valid); end
`ifdef EXEC_UNIT_MULDIV_EN
        drive_md(3'b100, 32'd1000, 32'd3, 5'd9);
        tick();
        bus.in_valid = 1'b0;
        repeat (10) tick();
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL flush_div_busy got=%b exp=1", bus.busy); end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++; if ({bus.busy, bus.out_valid, bus.in_ready} !== 3'b001) begin
            failures++; $display("FAIL flush_div_abort got busy=%b v=%b rdy=%b exp busy=0 v=0 rdy=1", bus.busy, bus.out_valid, bus.in_ready);
        end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL flush_div_no_result got=%0d exp=0", seen); end
`endif
    endtask

    task automatic test_reset_mid();
        int          lat, bcnt;
        logic [31:0] res;
        logic [4:0]  rtag;
`ifdef EXEC_UNIT_MULDIV_EN
        bus.out_ready = 1'b1;
        drive_md(3'b000, 32'd7, 32'd6, 5'd6);
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy got=%b exp=1", bus.busy); end
`else
        bus.out_ready = 1'b0;
        drive_alu(av[4], 5'd6);
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pending got=%b exp=1", bus.out_valid); end
`endif
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({bus.out_valid, bus.busy, bus.out_tag, bus.exec_out} !== 39'h0) begin
            failures++; $display("FAIL rstmid_async got v=%b busy=%b t=%h d=%h exp all 0", bus.out_valid, bus.busy, bus.out_tag, bus.exec_out);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", bus.in_ready); end
        run_md(3'b000, 32'd7, 32'd6, 5'd7, lat, bcnt, res, rtag);
`ifdef EXEC_UNIT_MULDIV_EN
        checks++; if ({lat == 33, res} !== {1'b1, 32'd42}) begin failures++; $display("FAIL rstmid_rerun got lat=%0d d=%h exp lat=33 d=0000002a", lat, res); end
`else
        checks++; if ({lat == 1, res} !== {1'b1, 32'd0}) begin failures++; $display("FAIL rstmid_rerun got lat=%0d d=%h exp lat=1 d=0", lat, res); end
`endif
    endtask

    initial begin
        av[0]  = '{4'b0000, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0000_0010, 32'h0000_0000};
        av[1]  = '{4'b1101, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
        av[2]  = '{4'b0010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        av[3]  = '{4'b0011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        av[4]  = '{4'b1000, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
        av[5]  = '{4'b0001, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0023, 32'h0000_0008};
        av[6]  = '{4'b0101, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
        av[7]  = '{4'b0100, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
        av[8]  = '{4'b0110, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0F00_0000, 32'hFFF0_F0F0};
        av[9]  = '{4'b0111, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        av[10] = '{4'b1110, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003};
        av[11] = '{4'b0000, 1'b1, 1'b1, 32'h0000_1000, 32'h0000_0004, 32'h0000_1004};

        mv[0]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
        mv[1]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        mv[2]  = '{3'b000, 32'd7,         32'd6,         32'd42,        1'b0};
        mv[3]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
        mv[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0};
        mv[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0};
        mv[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        1'b0};
        mv[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         1'b0};
        mv[8]  = '{3'b101, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 1'b1};
        mv[9]  = '{3'b110, 32'h0000_1234, 32'd0,         32'h0000_1234, 1'b1};
        mv[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        mv[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        mv[12] = '{3'b000, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 1'b0};
        mv[13] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0};

        test_reset();
        test_alu();
        test_back_to_back();
        test_backpressure();
        test_muldiv();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
